note_judge: RTL and testbench

Timing judge fed by the per-switch debouncer: consumes the debounced fret levels and debounced strum switch, and accepts expected notes from the chart sequencer over a valid/ready handshake. Each accepted note opens a hit window of `HIT_WINDOW` clocks. A strum inside the window is judged against the expected fret pattern, and a missing strum times out as a miss. It produces one-cycle hit/miss pulses plus running score and combo counters for the display stage.

---
 rtl/note_judge.sv | 131 +++++++++++++
 tb/tb_note_judge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge.sv
// note_judge: timing judge for a rhythm-game fret/strum controller.
// It takes expected notes from the chart sequencer over a valid/ready handshake
// and opens a hit window for each one. A strum inside the window is judged
// against the expected frets. A window that ends with no strum counts as a miss.
// The block keeps saturating score and combo counters.
// Optional feature: define GHOST_STRUM_PENALTY_EN to count a strum made while
// no note is pending (IDLE, no note accepted that cycle) as a miss.

module note_judge #(
    parameter int unsigned      LANES      = 5,
    parameter int unsigned      WIN_W      = 16,
    parameter logic [WIN_W-1:0] HIT_WINDOW = 16'd50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] fret_db,
    input  logic             strum_db,
    input  logic             note_valid,
    input  logic [LANES-1:0] note_lanes,
    output logic             note_ready,
    output logic             hit,
    output logic             miss,
    output logic [15:0]      score,
    output logic [7:0]       combo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HIT,
        S_MISS
    } state_t;

    // Last count value of the window. ARMED lasts HIT_WINDOW cycles in total.
    localparam logic [WIN_W-1:0] LAST_CNT = HIT_WINDOW - 1'b1;

`ifdef GHOST_STRUM_PENALTY_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] exp_q, exp_d;
    logic             strum_q;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;

    logic             strum_rise;
    logic [1:0]       score_step;
    logic [16:0]      score_sum;
    logic [15:0]      score_sat;
    logic [7:0]       combo_sat;

    // Judge only the rising edge of the strum. A strum held across states gives no new edge.
    assign strum_rise = strum_db & ~strum_q;

    // The hit bonus is chosen from the combo value before this hit increments it.
    assign score_step = (combo_q >= 8'd10) ? 2'd2 : 2'd1;
    assign score_sum  = {1'b0, score_q} + {15'b0, score_step};
    assign score_sat  = score_sum[16] ? '1 : score_sum[15:0];
    assign combo_sat  = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;

    // Next-state and counter-update logic. The counters change on the edge that enters HIT or MISS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        score_d = score_q;
        combo_d = combo_q;
        case (state_q)
            S_IDLE: begin
                if (note_valid && note_ready) begin
                    exp_d   = note_lanes;
                    cnt_d   = '0;
                    state_d = S_ARMED;
                end else if (GHOST_EN && strum_rise) begin
                    combo_d = '0;
                    state_d = S_MISS;
                end
            end
            S_ARMED: begin
                cnt_d = cnt_q + 1'b1;
                // A strum in the last window cycle is judged before the timeout applies.
                if (strum_rise) begin
                    if (fret_db == exp_q) begin
                        score_d = score_sat;
                        combo_d = combo_sat;
                        state_d = S_HIT;
                    end else begin
                        combo_d = '0;
                        state_d = S_MISS;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    combo_d = '0;
                    state_d = S_MISS;
                end
            end
            S_HIT:   state_d = S_IDLE;
            S_MISS:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset drops any note in flight, and no pulse is produced for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            strum_q <= 1'b0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            strum_q <= strum_db;
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign note_ready = (state_q == S_IDLE) && !rst;
    assign hit        = (state_q == S_HIT);
    assign miss       = (state_q == S_MISS);
    assign score      = score_q;
    assign combo      = combo_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed testbench for note_judge with HIT_WINDOW = 8.
// The expected values in this file were worked out by hand.
// Define GHOST_STRUM_PENALTY_EN when compiling to check the ghost-strum build.

module tb_note_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  fret_db;
    logic        strum_db;
    logic        note_valid;
    logic [4:0]  note_lanes;
    logic        note_ready;
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [7:0]  combo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    note_judge #(
        .LANES      (5),
        .WIN_W      (16),
        .HIT_WINDOW (16'd8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fret_db    (fret_db),
        .strum_db   (strum_db),
        .note_valid (note_valid),
        .note_lanes (note_lanes),
        .note_ready (note_ready),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .combo      (combo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Move 1 ns past the next rising edge. Inputs change here and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call this in IDLE with strum low. It plays one matching note: accept, strum in ARMED cycle 1, hit.
    task automatic play_hit(input logic [4:0] l, input logic [15:0] exp_s, input logic [7:0] exp_c);
        fret_db    = l;
        note_lanes = l;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        strum_db   = 1'b1;
        step();
        check("ph_hit", hit, 1);
        check("ph_miss", miss, 0);
        check("ph_score", score, exp_s);
        check("ph_combo", combo, exp_c);
        strum_db = 1'b0;
        step();
        check("ph_hit_end", hit, 0);
    endtask

    // Scores after each hit in a 12-hit run that starts from score 0 and combo 0.
    // The first 10 hits add 1 each. The hits made with combo 10 and combo 11 add 2 each.
    logic [15:0] run_score [12] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6,
                                    16'd7, 16'd8, 16'd9, 16'd10, 16'd12, 16'd14};

    int unsigned pulses;

    initial begin
        rst        = 1'b1;
        fret_db    = '0;
        strum_db   = 1'b0;
        note_valid = 1'b0;
        note_lanes = '0;

        // Values while reset is held
        repeat (3) step();
        check("rst_ready", note_ready, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        rst = 1'b0;
        #1;
        check("rel_ready", note_ready, 1);
        step();

        // Clean hit: the strum comes in ARMED cycle 3
        fret_db    = 5'b00101;
        note_lanes = 5'b00101;
        note_valid = 1'b1;
        check("clean_ready", note_ready, 1);
        step();
        note_valid = 1'b0;
        check("armed_ready", note_ready, 0);
        step();
        step();
        strum_db = 1'b1;
        step();
        check("clean_hit", hit, 1);
        check("clean_miss", miss, 0);
        check("clean_score", score, 1);
        check("clean_combo", combo, 1);
        strum_db = 1'b0;
        step();
        check("clean_hit_end", hit, 0);
        check("clean_idle_ready", note_ready, 1);

        // Boundary: the strum comes in the last window cycle (cnt = 7)
        fret_db    = 5'b01010;
        note_lanes = 5'b01010;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        repeat (7) step();
        check("bnd_nomiss_c8", miss, 0);
        strum_db = 1'b1;
        step();
        check("bnd_hit", hit, 1);
        check("bnd_miss", miss, 0);
        check("bnd_score", score, 2);
        check("bnd_combo", combo, 2);
        strum_db = 1'b0;
        step();

        // Wrong frets: an extra fret is pressed
        fret_db    = 5'b00111;
        note_lanes = 5'b00101;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        strum_db   = 1'b1;
        step();
        check("wrong_miss", miss, 1);
        check("wrong_hit", hit, 0);
        check("wrong_combo", combo, 0);
        check("wrong_score", score, 2);
        strum_db = 1'b0;
        step();

        play_hit(5'b00001, 16'd3, 8'd1);

        // Timeout: no strum, so miss goes high in the 9th cycle after acceptance
        fret_db    = 5'b00000;
        note_lanes = 5'b10000;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        repeat (7) step();
        check("to_nomiss_c8", miss, 0);
        check("to_ready_c8", note_ready, 0);
        step();
        check("to_miss_c9", miss, 1);
        check("to_combo", combo, 0);
        check("to_score", score, 3);
        step();
        check("to_miss_end", miss, 0);
        check("to_ready_end", note_ready, 1);

        play_hit(5'b11111, 16'd4, 8'd1);

        // Reset in the middle of ARMED: the note is dropped and no pulse follows
        fret_db    = 5'b00011;
        note_lanes = 5'b00011;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_score", score, 0);
        check("mid_rst_combo", combo, 0);
        check("mid_rst_ready", note_ready, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_miss", miss, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_ready", note_ready, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (hit || miss) pulses++;
        end
        check("mid_no_pulse", pulses, 0);
        check("mid_ready_after", note_ready, 1);

        // Twelve hits in a row, so the x2 bonus applies from combo 10
        for (int i = 0; i < 12; i++) begin
            play_hit(5'(i + 1), run_score[i], 8'(i + 1));
        end

        // Score saturation, starting from a value written into the score register
        force dut.score_q = 16'hFFFD;
        #1;
        release dut.score_q;
        #1;
        check("sat_preload", score, 16'hFFFD);
        play_hit(5'b00100, 16'hFFFF, 8'd13);
        play_hit(5'b00100, 16'hFFFF, 8'd14);

        // Ghost strum in IDLE with no note offered
        strum_db = 1'b1;
        step();
`ifdef GHOST_STRUM_PENALTY_EN
        check("ghost_miss", miss, 1);
        check("ghost_combo", combo, 0);
`else
        check("ghost_miss", miss, 0);
        check("ghost_combo", combo, 14);
`endif
        check("ghost_hit", hit, 0);
        strum_db = 1'b0;
        step();
        step();
        check("ghost_ready_after", note_ready, 1);

        // Strum in the same cycle as a note is accepted: the note wins, and the held strum gives no edge
        fret_db    = 5'b01000;
        note_lanes = 5'b01000;
        note_valid = 1'b1;
        strum_db   = 1'b1;
        step();
        note_valid = 1'b0;
        check("accstrum_nomiss", miss, 0);
        check("accstrum_armed", note_ready, 0);
        repeat (7) step();
        check("held_nohit_c8", hit, 0);
        check("held_nomiss_c8", miss, 0);
        step();
        check("held_timeout_miss", miss, 1);
        check("held_timeout_combo", combo, 0);
        strum_db = 1'b0;
        step();
        check("final_ready", note_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
